// File: rtl/dispatch_ctrl.sv
// Credit-based dispatch scheduler: gates instruction-queue pops on ROB/RS/free-list
// credits, sequences flush recovery and counts dispatch stall cycles.
module dispatch_ctrl #(
  parameter int SS             = 2,
  parameter int ROB_DEPTH      = 8,
  parameter int RS_DEPTH       = 8,
  parameter int PR_ENTRIES     = 64,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             inst_q_empty,
  output logic                             pop_inst_q,
  output logic                             avail_inst,
  input  logic [$clog2(SS+1)-1:0]          rob_ret_cnt,
  input  logic [$clog2(SS+1)-1:0]          rs_ret_cnt,
  input  logic [$clog2(SS+1)-1:0]          fl_ret_cnt,
  input  logic                             flush,
  input  logic [$clog2(PR_ENTRIES-31)-1:0] fl_restore_cnt,
  output logic [$clog2(ROB_DEPTH+1)-1:0]   rob_credits,
  output logic [$clog2(RS_DEPTH+1)-1:0]    rs_credits,
  output logic [$clog2(PR_ENTRIES-31)-1:0] fl_credits,
  output logic [2:0]                       stall_reason,
  output logic                             busy_recover,
  output logic [31:0]                      stall_cycles,
  output logic                             credit_err
);

  localparam int RW     = $clog2(ROB_DEPTH+1);
  localparam int SW     = $clog2(RS_DEPTH+1);
  localparam int FW     = $clog2(PR_ENTRIES-31);
  localparam int FL_MAX = PR_ENTRIES - 32;
  localparam int KW     = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  localparam logic [RW-1:0] ROB_NEED = RW'(SS);
  localparam logic [SW-1:0] RS_NEED  = SW'(SS);
  localparam logic [FW-1:0] FL_NEED  = FW'(SS);

  typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;

  state_t        state;
  logic [KW-1:0] recover_cnt;

  logic [31:0]   used;
  logic [31:0]   rob_sum, rs_sum, fl_sum;
  logic          rob_ovf, rs_ovf, fl_ovf, restore_ovf;
  logic [RW-1:0] rob_nxt;
  logic [SW-1:0] rs_nxt;
  logic [FW-1:0] fl_nxt, fl_restore_val;

  // Pop decision and next-credit arithmetic in 32 bits so overflow is visible before saturation.
  always_comb begin
    stall_reason = {fl_credits < FL_NEED, rs_credits < RS_NEED, rob_credits < ROB_NEED};
    pop_inst_q   = (state == RUN) && !flush && !inst_q_empty && (stall_reason == 3'b000);
    busy_recover = (state != RUN);

    used    = pop_inst_q ? 32'(SS) : 32'd0;
    rob_sum = 32'(rob_credits) - used + 32'(rob_ret_cnt);
    rs_sum  = 32'(rs_credits)  - used + 32'(rs_ret_cnt);
    fl_sum  = 32'(fl_credits)  - used + 32'(fl_ret_cnt);

    rob_ovf = rob_sum > 32'(ROB_DEPTH);
    rs_ovf  = rs_sum  > 32'(RS_DEPTH);
    fl_ovf  = fl_sum  > 32'(FL_MAX);

    rob_nxt = rob_ovf ? RW'(ROB_DEPTH) : rob_sum[RW-1:0];
    rs_nxt  = rs_ovf  ? SW'(RS_DEPTH)  : rs_sum[SW-1:0];
    fl_nxt  = fl_ovf  ? FW'(FL_MAX)    : fl_sum[FW-1:0];

    restore_ovf    = 32'(fl_restore_cnt) > 32'(FL_MAX);
    fl_restore_val = restore_ovf ? FW'(FL_MAX) : fl_restore_cnt;
  end

  // Flush wins over returns in its own cycle; otherwise credits follow the arithmetic above.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      recover_cnt  <= '0;
      rob_credits  <= RW'(ROB_DEPTH);
      rs_credits   <= SW'(RS_DEPTH);
      fl_credits   <= FW'(FL_MAX);
      avail_inst   <= 1'b0;
      stall_cycles <= '0;
      credit_err   <= 1'b0;
    end else begin
      avail_inst <= pop_inst_q && !flush;
      if (flush) begin
        state       <= FLUSH;
        rob_credits <= RW'(ROB_DEPTH);
        rs_credits  <= SW'(RS_DEPTH);
        fl_credits  <= fl_restore_val;
        if (restore_ovf) credit_err <= 1'b1;
      end else begin
        rob_credits <= rob_nxt;
        rs_credits  <= rs_nxt;
        fl_credits  <= fl_nxt;
        if (rob_ovf || rs_ovf || fl_ovf) credit_err <= 1'b1;
        case (state)
          RUN: begin
            if (!inst_q_empty && !pop_inst_q) stall_cycles <= stall_cycles + 32'd1;
          end
          FLUSH: begin
            state       <= RECOVER;
            recover_cnt <= KW'(RECOVER_CYCLES - 1);
          end
          RECOVER: begin
            if (recover_cnt == '0) state <= RUN;
            else recover_cnt <= recover_cnt - 1'b1;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: credit exhaustion, pop+return, flush recovery,
// overflow stickiness and reset during recovery, with hand-computed expectations.
module tb_dispatch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        inst_q_empty;
  logic        pop_inst_q;
  logic        avail_inst;
  logic [1:0]  rob_ret_cnt, rs_ret_cnt, fl_ret_cnt;
  logic        flush;
  logic [5:0]  fl_restore_cnt;
  logic [3:0]  rob_credits, rs_credits;
  logic [5:0]  fl_credits;
  logic [2:0]  stall_reason;
  logic        busy_recover;
  logic [31:0] stall_cycles;
  logic        credit_err;

  int errors = 0;
  int checks = 0;

  dispatch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst_q_empty(inst_q_empty), .pop_inst_q(pop_inst_q),
    .avail_inst(avail_inst), .rob_ret_cnt(rob_ret_cnt), .rs_ret_cnt(rs_ret_cnt),
    .fl_ret_cnt(fl_ret_cnt), .flush(flush), .fl_restore_cnt(fl_restore_cnt),
    .rob_credits(rob_credits), .rs_credits(rs_credits), .fl_credits(fl_credits),
    .stall_reason(stall_reason), .busy_recover(busy_recover),
    .stall_cycles(stall_cycles), .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic empty, input logic [1:0] rob_r, input logic [1:0] rs_r,
                               input logic [1:0] fl_r, input logic fl, input logic [5:0] restore);
    inst_q_empty   = empty;
    rob_ret_cnt    = rob_r;
    rs_ret_cnt     = rs_r;
    fl_ret_cnt     = fl_r;
    flush          = fl;
    fl_restore_cnt = restore;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst_rob", 32'(rob_credits), 32'd8);
    checkOutput("rst_rs", 32'(rs_credits), 32'd8);
    checkOutput("rst_fl", 32'(fl_credits), 32'd32);
    checkOutput("rst_avail", 32'(avail_inst), 32'd0);
    checkOutput("rst_reason", 32'(stall_reason), 32'd0);
    checkOutput("rst_err", 32'(credit_err), 32'd0);
    checkOutput("rst_busy", 32'(busy_recover), 32'd0);
    checkOutput("rst_stall", stall_cycles, 32'd0);
    checkOutput("rst_pop", 32'(pop_inst_q), 32'd0);
    nextCycle();

    // ROB exhaustion: RS and free list refilled each pop so only the ROB runs dry
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'd0, 2'd2, 2'd2, 1'b0, 6'd0);
      @(negedge clk);
      checkOutput($sformatf("exh_pop%0d", i), 32'(pop_inst_q), 32'd1);
      checkOutput($sformatf("exh_rob%0d", i), 32'(rob_credits), 32'(8 - 2*i));
      checkOutput($sformatf("exh_avail%0d", i), 32'(avail_inst), (i > 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("exh_rs%0d", i), 32'(rs_credits), 32'd8);
      checkOutput($sformatf("exh_fl%0d", i), 32'(fl_credits), 32'd32);
      nextCycle();
    end
    applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0);
    @(negedge clk);
    checkOutput("exh_pop4", 32'(pop_inst_q), 32'd0);
    checkOutput("exh_rob4", 32'(rob_credits), 32'd0);
    checkOutput("exh_avail4", 32'(avail_inst), 32'd1);
    checkOutput("exh_reason", 32'(stall_reason), 32'b001);
    checkOutput("exh_stall4", stall_cycles, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("exh_pop5", 32'(pop_inst_q), 32'd0);
    checkOutput("exh_avail5", 32'(avail_inst), 32'd0);
    checkOutput("exh_stall5", stall_cycles, 32'd1);
    nextCycle();

    // Return 2 ROB entries while stalled, then pop and return together
    applyStimulus(1'b0, 2'd2, 2'd0, 2'd0, 1'b0, 6'd0);
    @(negedge clk);
    checkOutput("ret_pop_c7", 32'(pop_inst_q), 32'd0);
    checkOutput("ret_stall_c7", stall_cycles, 32'd2);
    nextCycle();
    @(negedge clk);
    checkOutput("both_rob_c8", 32'(rob_credits), 32'd2);
    checkOutput("both_pop_c8", 32'(pop_inst_q), 32'd1);
    checkOutput("both_stall_c8", stall_cycles, 32'd3);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0);
    @(negedge clk);
    checkOutput("both_rob_c9", 32'(rob_credits), 32'd2);
    checkOutput("both_pop_c9", 32'(pop_inst_q), 32'd1);
    checkOutput("both_avail_c9", 32'(avail_inst), 32'd1);
    checkOutput("both_rs_c9", 32'(rs_credits), 32'd6);
    checkOutput("both_fl_c9", 32'(fl_credits), 32'd30);
    nextCycle();
    applyStimulus(1'b1, 2'd2, 2'd2, 2'd2, 1'b0, 6'd0);
    @(negedge clk);
    checkOutput("idle_rob_c10", 32'(rob_credits), 32'd0);
    checkOutput("idle_rs_c10", 32'(rs_credits), 32'd4);
    checkOutput("idle_pop_c10", 32'(pop_inst_q), 32'd0);
    checkOutput("idle_reason_c10", 32'(stall_reason), 32'b001);
    nextCycle();

    // Flush while pops are active
    applyStimulus(1'b0, 2'd2, 2'd2, 2'd2, 1'b0, 6'd0);
    @(negedge clk);
    checkOutput("pre_flush_pop", 32'(pop_inst_q), 32'd1);
    checkOutput("pre_flush_fl", 32'(fl_credits), 32'd30);
    nextCycle();
    applyStimulus(1'b0, 2'd2, 2'd2, 2'd2, 1'b1, 6'd20);
    @(negedge clk);
    checkOutput("flush_pop", 32'(pop_inst_q), 32'd0);
    checkOutput("flush_avail", 32'(avail_inst), 32'd1);
    checkOutput("flush_busy", 32'(busy_recover), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0);
    @(negedge clk);
    checkOutput("fl1_busy", 32'(busy_recover), 32'd1);
    checkOutput("fl1_rob", 32'(rob_credits), 32'd8);
    checkOutput("fl1_rs", 32'(rs_credits), 32'd8);
    checkOutput("fl1_fl", 32'(fl_credits), 32'd20);
    checkOutput("fl1_avail", 32'(avail_inst), 32'd0);
    checkOutput("fl1_pop", 32'(pop_inst_q), 32'd0);
    nextCycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rec%0d_busy", i), 32'(busy_recover), 32'd1);
      checkOutput($sformatf("rec%0d_pop", i), 32'(pop_inst_q), 32'd0);
      checkOutput($sformatf("rec%0d_avail", i), 32'(avail_inst), 32'd0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("resume_busy", 32'(busy_recover), 32'd0);
    checkOutput("resume_pop", 32'(pop_inst_q), 32'd1);
    checkOutput("resume_avail", 32'(avail_inst), 32'd0);
    checkOutput("resume_stall", stall_cycles, 32'd3);
    nextCycle();

    // Overflow: bring RS back to full, then return one more
    applyStimulus(1'b1, 2'd0, 2'd2, 2'd0, 1'b0, 6'd0);
    @(negedge clk);
    checkOutput("post_avail", 32'(avail_inst), 32'd1);
    checkOutput("post_rob", 32'(rob_credits), 32'd6);
    checkOutput("post_fl", 32'(fl_credits), 32'd18);
    checkOutput("post_stall", stall_cycles, 32'd3);
    nextCycle();
    applyStimulus(1'b1, 2'd0, 2'd1, 2'd0, 1'b0, 6'd0);
    @(negedge clk);
    checkOutput("ovf_rs_before", 32'(rs_credits), 32'd8);
    checkOutput("ovf_err_before", 32'(credit_err), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0);
    @(negedge clk);
    checkOutput("ovf_rs_after", 32'(rs_credits), 32'd8);
    checkOutput("ovf_err_after", 32'(credit_err), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("ovf_err_sticky", 32'(credit_err), 32'd1);
    nextCycle();

    // Reset during RECOVER
    applyStimulus(1'b1, 2'd0, 2'd0, 2'd0, 1'b1, 6'd10);
    nextCycle();
    applyStimulus(1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0);
    @(negedge clk);
    checkOutput("rr_flush_busy", 32'(busy_recover), 32'd1);
    checkOutput("rr_flush_fl", 32'(fl_credits), 32'd10);
    nextCycle();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rr_recover_busy", 32'(busy_recover), 32'd1);
    nextCycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rr_busy", 32'(busy_recover), 32'd0);
    checkOutput("rr_rob", 32'(rob_credits), 32'd8);
    checkOutput("rr_rs", 32'(rs_credits), 32'd8);
    checkOutput("rr_fl", 32'(fl_credits), 32'd32);
    checkOutput("rr_stall", stall_cycles, 32'd0);
    checkOutput("rr_err", 32'(credit_err), 32'd0);
    checkOutput("rr_avail", 32'(avail_inst), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0);
    @(negedge clk);
    checkOutput("rr_pop", 32'(pop_inst_q), 32'd1);
    nextCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
